// File: rtl/softmax_wb_pkg.sv
// Shared definitions for the softmax GBUS write-back path: FSM states,
// default geometry and the column one-hot helper.
package softmax_wb_pkg;

    localparam int WB_GBUS_DATA = 64;
    localparam int WB_MAC_NUM   = WB_GBUS_DATA / 8;
    localparam int WB_LANE_W    = WB_GBUS_DATA / WB_MAC_NUM;
    localparam int WB_MAX_COLS  = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_e;

    // Wide one-hot; callers size-cast down to their column count.
    function automatic logic [WB_MAX_COLS-1:0] col_onehot(input logic [7:0] sel);
        logic [WB_MAX_COLS-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/softmax_gbus_writer_fifo.sv
// Packed-word FIFO with a registered head stage; the head holds its last
// value once the FIFO drains, so the bus data stays stable when idle.
module wb_word_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             head_vld,
    output logic             head_load,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] head_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic             to_head_s;
    logic             from_mem_s;
    logic             to_mem_s;

    // Route each accepted word either straight into the head stage or into backing storage.
    always_comb begin
        do_pop_s   = pop & (cnt_r != CNT_W'(0));
        do_push_s  = push & ((cnt_r != CNT_W'(DEPTH)) | do_pop_s);
        from_mem_s = do_pop_s & (cnt_r > CNT_W'(1));
        to_head_s  = do_push_s & ((cnt_r == CNT_W'(0)) | (do_pop_s & (cnt_r == CNT_W'(1))));
        to_mem_s   = do_push_s & ~to_head_s;
    end

    // Occupancy, pointers and the head register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= CNT_W'(0);
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            head_r   <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
            if (to_head_s) begin
                head_r <= din;
            end else if (from_mem_s) begin
                head_r <= mem_r[rd_ptr_r];
            end else begin
                head_r <= head_r;
            end
            if (from_mem_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (to_mem_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
        end
    end

    // Backing storage behind the head stage.
    always_ff @(posedge clk) begin
        if (to_mem_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign full      = (cnt_r == CNT_W'(DEPTH));
    assign head_vld  = (cnt_r != CNT_W'(0));
    assign head_load = to_head_s | from_mem_s;
    assign head      = head_r;

endmodule

// File: rtl/softmax_gbus_writer.sv
// Softmax return path: packs per-lane results into GBUS words and writes them
// to one core column. Optional stall counter: SOFTMAX_WB_STALL_CNT_EN.
module softmax_gbus_writer
    import softmax_wb_pkg::*;
#(
    parameter int GBUS_DATA  = WB_GBUS_DATA,
    parameter int MAC_NUM    = GBUS_DATA / 8,
    parameter int GBUS_ADDR  = 12,
    parameter int VNUM       = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_start,
    input  logic [GBUS_ADDR-1:0]     cfg_base_addr,
    input  logic [GBUS_ADDR-1:0]     cfg_word_num,
    input  logic [$clog2(VNUM)-1:0]  cfg_col_sel,
    input  logic [GBUS_DATA-1:0]     odata,
    input  logic [MAC_NUM-1:0]       odata_valid,
    input  logic                     gbus_ready,
    output logic [VNUM-1:0]          gbus_wen,
    output logic [GBUS_ADDR-1:0]     gbus_waddr,
    output logic [GBUS_DATA-1:0]     gbus_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     lane_overrun
`ifdef SOFTMAX_WB_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int LANE_W = GBUS_DATA / MAC_NUM;

    wb_state_e            state_r;
    wb_state_e            state_s;
    logic [GBUS_ADDR-1:0] word_num_r;
    logic [GBUS_ADDR-1:0] addr_r;
    logic [GBUS_ADDR-1:0] waddr_r;
    logic [GBUS_ADDR-1:0] pack_cnt_r;
    logic [GBUS_ADDR-1:0] wr_cnt_r;
    logic [VNUM-1:0]      col_oh_r;
    logic [MAC_NUM-1:0]   mask_r;
    logic [MAC_NUM-1:0]   mask_s;
    logic [MAC_NUM-1:0]   arrive_s;
    logic [GBUS_DATA-1:0] pack_r;
    logic [GBUS_DATA-1:0] pack_s;
    logic [GBUS_DATA-1:0] push_word_s;
    logic                 complete_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 overrun_s;
    logic                 start_run_s;
    logic                 busy_r;
    logic                 done_r;
    logic                 lane_overrun_r;
    logic                 fifo_full_s;
    logic                 fifo_vld_s;
    logic                 fifo_head_load_s;
    logic [GBUS_DATA-1:0] fifo_head_s;

    // Lane packing: a lane already held either rolls into the next word (on push) or is an overrun.
    always_comb begin
        arrive_s    = (state_r == ST_RUN) ? odata_valid : '0;
        complete_s  = &(mask_r | arrive_s);
        pop_s       = fifo_vld_s & gbus_ready;
        push_s      = (state_r == ST_RUN) & complete_s & (~fifo_full_s | pop_s);
        overrun_s   = (|(arrive_s & mask_r)) & ~push_s;
        start_run_s = (state_r == ST_IDLE) & cfg_start & (cfg_word_num != GBUS_ADDR'(0));
        push_word_s = '0;
        pack_s      = pack_r;
        for (int i = 0; i < MAC_NUM; i++) begin
            push_word_s[i*LANE_W +: LANE_W] = mask_r[i] ? pack_r[i*LANE_W +: LANE_W]
                                                        : odata[i*LANE_W +: LANE_W];
            if (arrive_s[i] && (!mask_r[i] || push_s)) begin
                pack_s[i*LANE_W +: LANE_W] = odata[i*LANE_W +: LANE_W];
            end else begin
                pack_s[i*LANE_W +: LANE_W] = pack_r[i*LANE_W +: LANE_W];
            end
        end
        if (push_s) begin
            mask_s = arrive_s & mask_r;
        end else begin
            mask_s = mask_r | arrive_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_s = (cfg_word_num != GBUS_ADDR'(0)) ? ST_RUN : ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (push_s && ((pack_cnt_r + GBUS_ADDR'(1)) == word_num_r)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (pop_s && ((wr_cnt_r + GBUS_ADDR'(1)) == word_num_r)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            lane_overrun_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            busy_r         <= (state_s != ST_IDLE);
            done_r         <= (state_s == ST_DONE);
            lane_overrun_r <= lane_overrun_r | overrun_s;
        end
    end

    // Transfer configuration, counters, pack register and address tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_num_r <= GBUS_ADDR'(0);
            col_oh_r   <= VNUM'(0);
            addr_r     <= GBUS_ADDR'(0);
            waddr_r    <= GBUS_ADDR'(0);
            pack_cnt_r <= GBUS_ADDR'(0);
            wr_cnt_r   <= GBUS_ADDR'(0);
            mask_r     <= MAC_NUM'(0);
            pack_r     <= '0;
        end else begin
            if (start_run_s) begin
                word_num_r <= cfg_word_num;
                col_oh_r   <= VNUM'(col_onehot(8'(cfg_col_sel)));
                addr_r     <= cfg_base_addr;
                pack_cnt_r <= GBUS_ADDR'(0);
                wr_cnt_r   <= GBUS_ADDR'(0);
                mask_r     <= MAC_NUM'(0);
            end else begin
                word_num_r <= word_num_r;
                col_oh_r   <= col_oh_r;
                addr_r     <= addr_r + GBUS_ADDR'(pop_s);
                pack_cnt_r <= pack_cnt_r + GBUS_ADDR'(push_s);
                wr_cnt_r   <= wr_cnt_r + GBUS_ADDR'(pop_s);
                mask_r     <= mask_s;
            end
            pack_r <= pack_s;
            // The address follows the word that lands in the FIFO head stage.
            if (fifo_head_load_s) begin
                waddr_r <= pop_s ? (addr_r + GBUS_ADDR'(1)) : addr_r;
            end else begin
                waddr_r <= waddr_r;
            end
        end
    end

    wb_word_fifo #(
        .WIDTH (GBUS_DATA),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .din       (push_word_s),
        .full      (fifo_full_s),
        .head_vld  (fifo_vld_s),
        .head_load (fifo_head_load_s),
        .head      (fifo_head_s)
    );

    assign gbus_wen     = fifo_vld_s ? col_oh_r : VNUM'(0);
    assign gbus_waddr   = waddr_r;
    assign gbus_wdata   = fifo_head_s;
    assign busy         = busy_r;
    assign done         = done_r;
    assign lane_overrun = lane_overrun_r;

`ifdef SOFTMAX_WB_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of cycles where a write is offered but not accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'd0;
        end else if (start_run_s) begin
            stall_cnt_r <= 16'd0;
        end else if ((gbus_wen != VNUM'(0)) && !gbus_ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_softmax_gbus_writer.sv
// Directed bench for softmax_gbus_writer: table of per-cycle vectors plus
// hand-written backpressure and mid-transfer reset sequences.
module tb_softmax_gbus_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [11:0] cfg_base_addr;
    logic [11:0] cfg_word_num;
    logic [2:0]  cfg_col_sel;
    logic [63:0] odata;
    logic [7:0]  odata_valid;
    logic        gbus_ready;
    logic [7:0]  gbus_wen;
    logic [11:0] gbus_waddr;
    logic [63:0] gbus_wdata;
    logic        busy;
    logic        done;
    logic        lane_overrun;
`ifdef SOFTMAX_WB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    softmax_gbus_writer dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_start     (cfg_start),
        .cfg_base_addr (cfg_base_addr),
        .cfg_word_num  (cfg_word_num),
        .cfg_col_sel   (cfg_col_sel),
        .odata         (odata),
        .odata_valid   (odata_valid),
        .gbus_ready    (gbus_ready),
        .gbus_wen      (gbus_wen),
        .gbus_waddr    (gbus_waddr),
        .gbus_wdata    (gbus_wdata),
        .busy          (busy),
        .done          (done),
        .lane_overrun  (lane_overrun)
`ifdef SOFTMAX_WB_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    typedef struct {
        logic        start;
        logic [11:0] base;
        logic [11:0] num;
        logic [2:0]  col;
        logic [63:0] od;
        logic [7:0]  vld;
        logic        rdy;
        logic [7:0]  e_wen;
        logic [11:0] e_addr;
        logic [63:0] e_data;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vec [$];

    function automatic vec_t mkrow(input logic st, input logic [11:0] b, input logic [11:0] n,
                                   input logic [2:0] c, input logic [63:0] d, input logic [7:0] v,
                                   input logic r, input logic [7:0] ew, input logic [11:0] ea,
                                   input logic [63:0] edat, input logic eb, input logic edn);
        vec_t x;
        x.start = st;  x.base = b;    x.num = n;      x.col = c;
        x.od = d;      x.vld = v;     x.rdy = r;
        x.e_wen = ew;  x.e_addr = ea; x.e_data = edat; x.e_busy = eb; x.e_done = edn;
        return x;
    endfunction

    function automatic logic [63:0] mk_word(input int k);
        logic [63:0] w;
        for (int l = 0; l < 8; l++) begin
            w[l*8 +: 8] = 8'(k * 16 + l);
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] ew, input logic [11:0] ea,
                            input logic [63:0] edat, input logic eb, input logic edn, input logic eo);
        chk({tag, ".wen"},   64'(gbus_wen),     64'(ew));
        chk({tag, ".waddr"}, 64'(gbus_waddr),   64'(ea));
        chk({tag, ".wdata"}, gbus_wdata,        edat);
        chk({tag, ".busy"},  64'(busy),         64'(eb));
        chk({tag, ".done"},  64'(done),         64'(edn));
        chk({tag, ".ovr"},   64'(lane_overrun), 64'(eo));
    endtask

    initial begin
        int          ord [8];
        logic [63:0] d;
        ord = '{7, 0, 3, 1, 6, 2, 5, 4};

        rst = 1'b1; cfg_start = 1'b0; cfg_base_addr = 12'h000; cfg_word_num = 12'h000;
        cfg_col_sel = 3'd0; odata = 64'h0; odata_valid = 8'h00; gbus_ready = 1'b1;
        tick();
        tick();
        chk_outs("reset", 8'h00, 12'h000, 64'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Two full words to column 3 at 0x010
        vec.push_back(mkrow(1'b1, 12'h010, 12'd2, 3'd3, 64'h0, 8'h00, 1'b1, 8'h00, 12'h000, 64'h0, 1'b1, 1'b0));
        vec.push_back(mkrow(1'b0, 12'h000, 12'd0, 3'd0, 64'h0706050403020100, 8'hFF, 1'b1, 8'h08, 12'h010, 64'h0706050403020100, 1'b1, 1'b0));
        vec.push_back(mkrow(1'b0, 12'h000, 12'd0, 3'd0, 64'h0F0E0D0C0B0A0908, 8'hFF, 1'b1, 8'h08, 12'h011, 64'h0F0E0D0C0B0A0908, 1'b1, 1'b0));
        vec.push_back(mkrow(1'b0, 12'h000, 12'd0, 3'd0, 64'h0, 8'h00, 1'b1, 8'h00, 12'h011, 64'h0F0E0D0C0B0A0908, 1'b1, 1'b1));
        vec.push_back(mkrow(1'b0, 12'h000, 12'd0, 3'd0, 64'h0, 8'h00, 1'b1, 8'h00, 12'h011, 64'h0F0E0D0C0B0A0908, 1'b0, 1'b0));
        // Out-of-order single lanes, one word to column 0 at 0x020
        vec.push_back(mkrow(1'b1, 12'h020, 12'd1, 3'd0, 64'h0, 8'h00, 1'b1, 8'h00, 12'h011, 64'h0F0E0D0C0B0A0908, 1'b1, 1'b0));
        for (int j = 0; j < 8; j++) begin
            d = 64'hEEEEEEEEEEEEEEEE;
            d[ord[j]*8 +: 8] = 8'(8'hA0 + ord[j]);
            if (j < 7) begin
                vec.push_back(mkrow(1'b0, 12'h000, 12'd0, 3'd0, d, 8'(1 << ord[j]), 1'b1, 8'h00, 12'h011, 64'h0F0E0D0C0B0A0908, 1'b1, 1'b0));
            end else begin
                vec.push_back(mkrow(1'b0, 12'h000, 12'd0, 3'd0, d, 8'(1 << ord[j]), 1'b1, 8'h01, 12'h020, 64'hA7A6A5A4A3A2A1A0, 1'b1, 1'b0));
            end
        end
        vec.push_back(mkrow(1'b0, 12'h000, 12'd0, 3'd0, 64'h0, 8'h00, 1'b1, 8'h00, 12'h020, 64'hA7A6A5A4A3A2A1A0, 1'b1, 1'b1));
        vec.push_back(mkrow(1'b0, 12'h000, 12'd0, 3'd0, 64'h0, 8'h00, 1'b1, 8'h00, 12'h020, 64'hA7A6A5A4A3A2A1A0, 1'b0, 1'b0));
        // Address wrap 0xFFE -> 0xFFF -> 0x000, column 7
        vec.push_back(mkrow(1'b1, 12'hFFE, 12'd3, 3'd7, 64'h0, 8'h00, 1'b1, 8'h00, 12'h020, 64'hA7A6A5A4A3A2A1A0, 1'b1, 1'b0));
        vec.push_back(mkrow(1'b0, 12'h000, 12'd0, 3'd0, 64'h1111111111111111, 8'hFF, 1'b1, 8'h80, 12'hFFE, 64'h1111111111111111, 1'b1, 1'b0));
        vec.push_back(mkrow(1'b0, 12'h000, 12'd0, 3'd0, 64'h2222222222222222, 8'hFF, 1'b1, 8'h80, 12'hFFF, 64'h2222222222222222, 1'b1, 1'b0));
        vec.push_back(mkrow(1'b0, 12'h000, 12'd0, 3'd0, 64'h3333333333333333, 8'hFF, 1'b1, 8'h80, 12'h000, 64'h3333333333333333, 1'b1, 1'b0));
        vec.push_back(mkrow(1'b0, 12'h000, 12'd0, 3'd0, 64'h0, 8'h00, 1'b1, 8'h00, 12'h000, 64'h3333333333333333, 1'b1, 1'b1));
        vec.push_back(mkrow(1'b0, 12'h000, 12'd0, 3'd0, 64'h0, 8'h00, 1'b1, 8'h00, 12'h000, 64'h3333333333333333, 1'b0, 1'b0));
        // Zero-length transfer: done one cycle after start, no write
        vec.push_back(mkrow(1'b1, 12'h123, 12'd0, 3'd0, 64'h0, 8'h00, 1'b1, 8'h00, 12'h000, 64'h3333333333333333, 1'b1, 1'b1));
        vec.push_back(mkrow(1'b0, 12'h000, 12'd0, 3'd0, 64'h0, 8'h00, 1'b1, 8'h00, 12'h000, 64'h3333333333333333, 1'b0, 1'b0));
        // Start pulses while busy must be ignored
        vec.push_back(mkrow(1'b1, 12'h040, 12'd2, 3'd1, 64'h0, 8'h00, 1'b1, 8'h00, 12'h000, 64'h3333333333333333, 1'b1, 1'b0));
        vec.push_back(mkrow(1'b1, 12'h300, 12'd5, 3'd2, 64'h4444444444444444, 8'hFF, 1'b1, 8'h02, 12'h040, 64'h4444444444444444, 1'b1, 1'b0));
        vec.push_back(mkrow(1'b1, 12'h300, 12'd5, 3'd2, 64'h5555555555555555, 8'hFF, 1'b1, 8'h02, 12'h041, 64'h5555555555555555, 1'b1, 1'b0));
        vec.push_back(mkrow(1'b0, 12'h000, 12'd0, 3'd0, 64'h0, 8'h00, 1'b1, 8'h00, 12'h041, 64'h5555555555555555, 1'b1, 1'b1));
        vec.push_back(mkrow(1'b0, 12'h000, 12'd0, 3'd0, 64'h0, 8'h00, 1'b1, 8'h00, 12'h041, 64'h5555555555555555, 1'b0, 1'b0));

        foreach (vec[i]) begin
            cfg_start     = vec[i].start;
            cfg_base_addr = vec[i].base;
            cfg_word_num  = vec[i].num;
            cfg_col_sel   = vec[i].col;
            odata         = vec[i].od;
            odata_valid   = vec[i].vld;
            gbus_ready    = vec[i].rdy;
            tick();
            chk_outs($sformatf("row%0d", i), vec[i].e_wen, vec[i].e_addr, vec[i].e_data,
                     vec[i].e_busy, vec[i].e_done, 1'b0);
        end
        cfg_start = 1'b0; odata_valid = 8'h00;

        // Backpressure: FIFO fills, 5th word held, 6th word overruns
        cfg_start = 1'b1; cfg_base_addr = 12'h080; cfg_word_num = 12'd5; cfg_col_sel = 3'd0;
        gbus_ready = 1'b0;
        tick();
        cfg_start = 1'b0;
        chk_outs("bp.start", 8'h00, 12'h041, 64'h5555555555555555, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            odata = mk_word(k); odata_valid = 8'hFF;
            tick();
            chk_outs($sformatf("bp.fill%0d", k), 8'h01, 12'h080, mk_word(1), 1'b1, 1'b0, 1'b0);
        end
        odata = mk_word(6); odata_valid = 8'hFF;
        tick();
        chk_outs("bp.overrun", 8'h01, 12'h080, mk_word(1), 1'b1, 1'b0, 1'b1);
        odata_valid = 8'h00;
        for (int k = 0; k < 14; k++) begin
            tick();
            chk_outs($sformatf("bp.stall%0d", k), 8'h01, 12'h080, mk_word(1), 1'b1, 1'b0, 1'b1);
        end
        gbus_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk_outs($sformatf("bp.write%0d", k), 8'h01, 12'(12'h080 + k - 1), mk_word(k), 1'b1, 1'b0, 1'b1);
        end
        tick();
        chk_outs("bp.done", 8'h00, 12'h084, mk_word(5), 1'b1, 1'b1, 1'b1);
        tick();
        chk_outs("bp.idle", 8'h00, 12'h084, mk_word(5), 1'b0, 1'b0, 1'b1);

        // Reset after one of four words written; partial lanes must not leak
        cfg_start = 1'b1; cfg_base_addr = 12'h100; cfg_word_num = 12'd4; cfg_col_sel = 3'd2;
        gbus_ready = 1'b0;
        tick();
        cfg_start = 1'b0;
        odata = mk_word(7); odata_valid = 8'hFF;
        tick();
        chk_outs("rs.first", 8'h04, 12'h100, mk_word(7), 1'b1, 1'b0, 1'b1);
        gbus_ready = 1'b1; odata = mk_word(8); odata_valid = 8'h0F;
        tick();
        chk_outs("rs.written", 8'h00, 12'h100, mk_word(7), 1'b1, 1'b0, 1'b1);
        rst = 1'b1; odata = mk_word(9); odata_valid = 8'hFF;
        tick();
        chk_outs("rs.reset", 8'h00, 12'h000, 64'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; odata_valid = 8'h00;
        cfg_start = 1'b1; cfg_base_addr = 12'h200; cfg_word_num = 12'd1; cfg_col_sel = 3'd5;
        tick();
        cfg_start = 1'b0;
        chk_outs("rs.restart", 8'h00, 12'h000, 64'h0, 1'b1, 1'b0, 1'b0);
        odata = mk_word(10); odata_valid = 8'hFF;
        tick();
        chk_outs("rs.write", 8'h20, 12'h200, mk_word(10), 1'b1, 1'b0, 1'b0);
        odata_valid = 8'h00;
        tick();
        chk_outs("rs.done", 8'h00, 12'h200, mk_word(10), 1'b1, 1'b1, 1'b0);
        tick();
        chk_outs("rs.idle", 8'h00, 12'h200, mk_word(10), 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/softmax_gbus_writer.md
Name: softmax_gbus_writer

Overview:
- Return path of the softmax unit. Collects per-lane softmax results, which arrive on the softmax output bus with an individual valid per MAC lane.
- Packs them into full GBUS words and writes them back into one core column over the global bus.
- One instance per head, placed between the softmax bus and the core array's gbus write port. Handles bus backpressure through a small word FIFO.

Parameters:
- GBUS_DATA, 64, global bus word width in bits
- MAC_NUM, GBUS_DATA/8, number of lanes per word; lane width is GBUS_DATA/MAC_NUM
- GBUS_ADDR, 12, gbus address width
- VNUM, 8, number of columns in the head
- FIFO_DEPTH, 4, packed-word FIFO depth; power of 2, at least 2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_start  in  1  one-cycle pulse; starts a transfer; ignored unless the FSM is in IDLE
- cfg_base_addr  in  GBUS_ADDR  first write address, latched on start
- cfg_word_num  in  GBUS_ADDR  number of words to write, latched on start; 0 means no transfer
- cfg_col_sel  in  $clog2(VNUM)  target column, latched on start
- odata  in  GBUS_DATA  softmax output word; lane i occupies bits [i*W +: W], where W is the lane width
- odata_valid  in  MAC_NUM  per-lane valid
- gbus_ready  in  1  bus accepts the current write
- gbus_wen  out  VNUM  one-hot column write enable
- gbus_waddr  out  GBUS_ADDR  write address
- gbus_wdata  out  GBUS_DATA  write data
- busy  out  1  high while the FSM is not IDLE
- done  out  1  one-cycle pulse when the last word is accepted
- lane_overrun  out  1  sticky error flag

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) returns the block to its reset state. This applies mid-transfer too: the partial word and FIFO are discarded.
  - All outputs are 0; FSM is IDLE.
  - Lane mask, FIFO pointers, word counters and lane_overrun are cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on cfg_start when cfg_word_num != 0. Config is latched at this point; the address register is set to cfg_base_addr.
  - IDLE -> DONE on cfg_start when cfg_word_num == 0.
  - RUN -> DRAIN when the packed-word count reaches word_num.
  - DRAIN -> DONE when the written-word count reaches word_num.
  - DONE -> IDLE unconditionally. done=1 only in the DONE cycle.
- Packing (RUN only; odata_valid is ignored in all other states):
  - For each lane i with odata_valid[i]=1, the lane's data is stored in the pack register and mask[i] is set.
  - A word is complete when the mask is all ones (including lanes arriving this cycle).
  - A complete word is pushed into the FIFO in that same cycle if the FIFO is not full. The mask then clears, except for lanes that belong to the next word.
  - If the FIFO is full, the complete word is held. A lane arriving while its mask bit is already set and no push happens that cycle sets lane_overrun, and the new data is dropped.
  - A lane arriving in the same cycle its old word is pushed is legal and starts the next word.
  - Packed-word latency: a push in cycle N makes the word visible on the gbus outputs in cycle N+1 (registered FIFO output).
- Bus write:
  - When the FIFO is non-empty, drive gbus_wen = onehot(col_sel), gbus_waddr = current address, gbus_wdata = FIFO head. All are held stable until gbus_ready=1.
  - On ready: pop the FIFO, increment the address modulo 2^GBUS_ADDR (0xFFF wraps to 0x000), increment the written-word count.
  - When the FIFO is empty, gbus_wen=0 and gbus_waddr/gbus_wdata hold their last values.
  - A FIFO push and pop in the same cycle is allowed when full; occupancy is unchanged.
- cfg_start while busy is ignored. lane_overrun is cleared only by rst.

Optional Feature:
- Macro SOFTMAX_WB_STALL_CNT_EN.
  - Defined: adds output stall_cnt [15:0], which counts cycles with gbus_wen!=0 and gbus_ready=0. It is cleared on IDLE->RUN and saturates at 0xFFFF.
  - Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package softmax_wb_pkg:
  - FSM state enum
  - lane-width constant GBUS_DATA/MAC_NUM
  - onehot column-select helper function
- One sub-module: wb_word_fifo (synchronous FIFO, width GBUS_DATA, depth FIFO_DEPTH, with full/empty and registered head output).

Test Plan:
- Start with base=0x010, num=2, col=3, gbus_ready=1; all 8 lanes valid for 2 cycles with bytes 0x00..0x0F. Expect:
  - gbus_wen=0x08 at addr 0x010 with data 0x0706050403020100, then addr 0x011 with data 0x0F0E0D0C0B0A0908
  - done pulse; busy then 0
- Lanes arrive out of order, one per cycle (7,0,3,...); num=1. Expect a single write with each byte in its lane position, issued one cycle after the 8th lane.
- gbus_ready=0 for 20 cycles while 6 full words arrive, with FIFO_DEPTH=4. Expect:
  - the 5th word held in the pack register
  - a repeat lane-0 arrival sets lane_overrun=1 and its data is dropped
  - after ready returns, 5 writes in order
- base=0xFFE, num=3. Expect addresses 0xFFE, 0xFFF, 0x000.
- rst asserted after 1 of 4 words is written. Expect next cycle: all outputs 0, busy=0. A new start then writes from the new base with no stale data.
- cfg_word_num=0 gives a done pulse 1 cycle after start with no gbus_wen. A cfg_start during RUN is ignored (address continues unchanged).
